flash_sample_streamer: RTL

- Parametrised successor to the flash music reader.
- Streams multi-byte PCM samples from parallel NOR flash to the audio interface, one sample per codec request.
- Handles a table of NUM_SONGS songs, play/pause, restart, next/prev with wrap, and auto-advance at end of song.
- Speed control uses sample stepping on a single clock; there is no clock muxing.

---
 rtl/flash_sample_streamer_if.sv | 28 ++
 rtl/flash_sample_streamer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/flash_sample_streamer_if.sv
// flash_sample_streamer_if
//   Parallel NOR flash read bus between the sample streamer and the flash.
//   Parameter ADDR_W : flash byte-address width.
//   Signals:
//     FL_ADDR  [ADDR_W-1:0]  byte address (streamer -> flash)
//     FL_DQ    [7:0]         read data    (flash -> streamer)
//     FL_OE_N, FL_CE_N, FL_WE_N, FL_RST_N  active-low strobes (streamer -> flash)
//   Modports: master = streamer side, slave = flash side.
interface flash_sample_streamer_if #(
  parameter int ADDR_W = 23
);
  logic [ADDR_W-1:0] FL_ADDR;
  logic [7:0]        FL_DQ;
  logic              FL_OE_N;
  logic              FL_CE_N;
  logic              FL_WE_N;
  logic              FL_RST_N;

  modport master (
    output FL_ADDR, FL_OE_N, FL_CE_N, FL_WE_N, FL_RST_N,
    input  FL_DQ
  );

  modport slave (
    input  FL_ADDR, FL_OE_N, FL_CE_N, FL_WE_N, FL_RST_N,
    output FL_DQ
  );
endinterface

// File: rtl/flash_sample_streamer.sv
// flash_sample_streamer
//   Streams little-endian multi-byte PCM samples from parallel NOR flash to
//   the codec, one sample per sample_req pulse. Keeps a table of songs with
//   play/pause, restart, next/prev (wrapping) and auto-advance at song end.
//   Speed is done by sample stepping: fast skips every other sample, slow
//   serves each sample twice.
//
//   Ports:
//     clk, Reset        clock, synchronous active-high reset
//     sample_req        codec pulse: consume one sample
//     play_pause        pulse: toggle playing
//     restart           pulse: jump to start of current song
//     next_song         pulse: song+1 (wraps to 0)
//     prev_song         pulse: song-1 (wraps to NUM_SONGS-1)
//     speed [1:0]       00/11 normal, 01 fast, 10 slow
//     fl                flash bus (master modport)
//     sample_out [SW]   sample presented to the codec
//     song_idx [SI_W]   current song
//     playing           1 = playing, 0 = paused
//     underrun_cnt[16]  only with FLASH_STREAMER_UNDERRUN_CNT_EN defined:
//                       saturating count of requests served from an empty
//                       buffer, cleared on any song change
//
//   State | meaning
//   SETUP | clear byte/wait counters, decide whether to fetch
//   FETCH | flash enabled, reading the bytes of one sample
//   HOLD  | sample buffered (or paused), wait for it to be consumed
module flash_sample_streamer #(
  parameter int ADDR_W       = 23,
  parameter int SAMPLE_BYTES = 2,
  parameter int NUM_SONGS    = 2,
  parameter logic [(NUM_SONGS+1)*ADDR_W-1:0] SONG_BOUNDS =
    {23'd4194304, 23'd2274217, 23'd0},
  parameter int FLASH_WAIT   = 4,
  localparam int SW   = 8 * SAMPLE_BYTES,
  localparam int SI_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
  input  logic                           clk,
  input  logic                           Reset,
  input  logic                           sample_req,
  input  logic                           play_pause,
  input  logic                           restart,
  input  logic                           next_song,
  input  logic                           prev_song,
  input  logic [1:0]                     speed,
  flash_sample_streamer_if.master        fl,
  output logic [SW-1:0]                  sample_out,
  output logic [SI_W-1:0]                song_idx,
  output logic                           playing
`ifdef FLASH_STREAMER_UNDERRUN_CNT_EN
  , output logic [15:0]                  underrun_cnt
`endif
);

  localparam int BC_W = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
  localparam int WC_W = (FLASH_WAIT > 1) ? $clog2(FLASH_WAIT) : 1;

  typedef enum logic [1:0] {SETUP, FETCH, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] sample_idx;
  logic [BC_W-1:0]   byte_ctr;
  logic [WC_W-1:0]   wait_ctr;
  logic [SW-1:0]     sample_buf;
  logic              buf_full;
  logic              served_once;

  logic              fl_active, byte_done, sample_done;
  logic              take_prev, take_next, take_restart, take_pp, take_req, take_auto;
  logic              song_chg;
  logic [SI_W-1:0]   song_inc, song_dec, song_tgt;
  logic [ADDR_W-1:0] end_bound, step_amt, byte_addr;
  logic              at_end, slow;

  function automatic logic [ADDR_W-1:0] song_bound(input int i);
    return SONG_BOUNDS[i*ADDR_W +: ADDR_W];
  endfunction

  assign song_inc  = (song_idx == SI_W'(NUM_SONGS - 1)) ? '0 : song_idx + SI_W'(1);
  assign song_dec  = (song_idx == '0) ? SI_W'(NUM_SONGS - 1) : song_idx - SI_W'(1);
  assign end_bound = song_bound(int'(song_idx) + 1);
  // The index is advanced when a sample is fetched, so the end is only acted
  // on once that last buffered sample has been consumed.
  assign at_end    = (sample_idx >= end_bound);
  assign step_amt  = (speed == 2'b01) ? ADDR_W'(2) : ADDR_W'(1);
  assign slow      = (speed == 2'b10);
  assign byte_addr = sample_idx * ADDR_W'(SAMPLE_BYTES) + ADDR_W'(byte_ctr);

  // Fixed priority; anything below the winner is dropped for this cycle.
  assign take_prev    = prev_song;
  assign take_next    = !prev_song && next_song;
  assign take_restart = !prev_song && !next_song && restart;
  assign take_pp      = !prev_song && !next_song && !restart && play_pause;
  assign take_req     = !prev_song && !next_song && !restart && !play_pause && sample_req;
  assign take_auto    = !prev_song && !next_song && !restart && !play_pause && !sample_req
                        && !buf_full && at_end;
  assign song_chg     = take_prev || take_next || take_restart || take_auto;

  always_comb begin
    song_tgt = song_idx;
    if (take_prev)
      song_tgt = song_dec;
    else if (take_next || take_auto)
      song_tgt = song_inc;
  end

  assign fl.FL_ADDR  = fl_active ? byte_addr : '0;
  assign fl.FL_CE_N  = !fl_active;
  assign fl.FL_OE_N  = !fl_active;
  assign fl.FL_WE_N  = 1'b1;
  assign fl.FL_RST_N = 1'b1;

  always_ff @(posedge clk) begin
    if (Reset)
      state <= SETUP;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    fl_active   = 1'b0;
    byte_done   = 1'b0;
    sample_done = 1'b0;
    case (state)
      SETUP: state_nxt = (playing && !buf_full) ? FETCH : HOLD;
      FETCH: begin
        fl_active = 1'b1;
        if (wait_ctr == WC_W'(FLASH_WAIT - 1)) begin
          byte_done = 1'b1;
          if (byte_ctr == BC_W'(SAMPLE_BYTES - 1)) begin
            sample_done = 1'b1;
            state_nxt   = HOLD;
          end
        end
      end
      HOLD: if (!buf_full && playing) state_nxt = SETUP;
      default: state_nxt = SETUP;
    endcase
    if (song_chg)
      state_nxt = SETUP;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      sample_idx  <= song_bound(0);
      byte_ctr    <= '0;
      wait_ctr    <= '0;
      sample_buf  <= '0;
      buf_full    <= 1'b0;
      served_once <= 1'b0;
      sample_out  <= '0;
      song_idx    <= '0;
      playing     <= 1'b1;
    end else if (song_chg) begin
      sample_idx  <= song_bound(int'(song_tgt));
      song_idx    <= song_tgt;
      byte_ctr    <= '0;
      wait_ctr    <= '0;
      buf_full    <= 1'b0;
      served_once <= 1'b0;
      sample_out  <= '0;
    end else begin
      if (take_pp)
        playing <= !playing;

      if (state == SETUP) begin
        byte_ctr <= '0;
        wait_ctr <= '0;
      end

      if (state == FETCH) begin
        if (byte_done) begin
          sample_buf[{byte_ctr, 3'b000} +: 8] <= fl.FL_DQ;
          wait_ctr <= '0;
          if (!sample_done)
            byte_ctr <= byte_ctr + BC_W'(1);
        end else begin
          wait_ctr <= wait_ctr + WC_W'(1);
        end
        if (sample_done) begin
          buf_full    <= 1'b1;
          served_once <= 1'b0;
          sample_idx  <= sample_idx + step_amt;
        end
      end

      if (take_req) begin
        if (!playing) begin
          sample_out <= '0;
        end else if (buf_full) begin
          sample_out <= sample_buf;
          if (slow && !served_once) begin
            served_once <= 1'b1;
          end else begin
            buf_full    <= 1'b0;
            served_once <= 1'b0;
          end
        end
      end
    end
  end

`ifdef FLASH_STREAMER_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (Reset || song_chg)
      underrun_cnt <= '0;
    else if (take_req && playing && !buf_full && (underrun_cnt != 16'hFFFF))
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule
